// File: rtl/rf_acc_param.sv
// Parametrised register file with two combinational read ports, write protection,
// an aliased accumulator and a registered illegal-write error pulse. Optional macro: RF_BYPASS_EN.
module rf_acc_param #(
  parameter int               W         = 8,
  parameter int               DEPTH     = 16,
  parameter int               AW        = $clog2(DEPTH),
  parameter logic [DEPTH-1:0] PROT_MASK = 16'hC000,
  parameter int               ACC_IDX   = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] ptr_w,
  input  logic [W-1:0]  di,
  input  logic [AW-1:0] ptr_a,
  input  logic [AW-1:0] ptr_b,
  output logic [W-1:0]  do_a,
  output logic [W-1:0]  do_b,
  output logic          vld_a,
  output logic          vld_b,
  input  logic          acc_we,
  input  logic          acc_clr,
  input  logic [W-1:0]  acc,
  output logic [W-1:0]  do_acc,
  output logic          wr_err
);

  localparam logic [AW-1:0] ACC_PTR = AW'(ACC_IDX);

  logic [W-1:0]     core [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [W-1:0]     acc_q;
  logic             wr_err_q;
  logic             prot;
  logic             wr_ok;

  assign prot  = PROT_MASK[ptr_w];
  assign wr_ok = we && !prot;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) core[i] <= '0;
      valid    <= '0;
      acc_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        core[ptr_w]  <= di;
        valid[ptr_w] <= 1'b1;
      end
      wr_err_q <= we && prot;
      if (acc_clr)     acc_q <= '0;
      else if (acc_we) acc_q <= acc;
    end
  end

`ifdef RF_BYPASS_EN
  logic [W-1:0] acc_next;

  always_comb begin
    acc_next = acc_q;
    if (acc_clr)     acc_next = '0;
    else if (acc_we) acc_next = acc;
  end
`endif

  always_comb begin
    do_a  = core[ptr_a];
    vld_a = valid[ptr_a];
    do_b  = core[ptr_b];
    vld_b = valid[ptr_b];
`ifdef RF_BYPASS_EN
    // Write-first forwarding; the accumulator alias forwards its next value instead
    if (ptr_a == ACC_PTR) begin
      do_a  = acc_next;
      vld_a = 1'b1;
    end else if (wr_ok && ptr_a == ptr_w) begin
      do_a  = di;
      vld_a = 1'b1;
    end
    if (ptr_b == ACC_PTR) begin
      do_b  = acc_next;
      vld_b = 1'b1;
    end else if (wr_ok && ptr_b == ptr_w) begin
      do_b  = di;
      vld_b = 1'b1;
    end
`else
    if (ptr_a == ACC_PTR) begin
      do_a  = acc_q;
      vld_a = 1'b1;
    end
    if (ptr_b == ACC_PTR) begin
      do_b  = acc_q;
      vld_b = 1'b1;
    end
`endif
  end

  assign do_acc = acc_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_rf_acc_param.sv
// Randomised and directed bench for rf_acc_param against a behavioural model.
module tb_rf_acc_param;

  logic       clk = 1'b0;
  logic       reset, we, acc_we, acc_clr;
  logic [3:0] ptr_w, ptr_a, ptr_b;
  logic [7:0] di, acc_in;
  logic [7:0] do_a, do_b, do_acc;
  logic       vld_a, vld_b, wr_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_core [16];
  logic       m_vld  [16];
  logic [7:0] m_acc;
  logic       m_err;

  always #5 clk = ~clk;

  rf_acc_param dut (
    .clk(clk), .reset(reset), .we(we), .ptr_w(ptr_w), .di(di),
    .ptr_a(ptr_a), .ptr_b(ptr_b), .do_a(do_a), .do_b(do_b),
    .vld_a(vld_a), .vld_b(vld_b), .acc_we(acc_we), .acc_clr(acc_clr),
    .acc(acc_in), .do_acc(do_acc), .wr_err(wr_err)
  );

  // Addresses 14 and 15 are write-protected by default
  function automatic bit is_prot(input logic [3:0] a);
    return a >= 4'd14;
  endfunction

  function automatic bit bypass_on();
`ifdef RF_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_do(input logic [3:0] p);
    if (p == 4'd15) begin
      if (bypass_on() && acc_clr) return 8'h00;
      if (bypass_on() && acc_we)  return acc_in;
      return m_acc;
    end
    if (bypass_on() && we && !is_prot(ptr_w) && p == ptr_w) return di;
    return m_core[p];
  endfunction

  function automatic logic exp_vld(input logic [3:0] p);
    if (p == 4'd15) return 1'b1;
    if (bypass_on() && we && !is_prot(ptr_w) && p == ptr_w) return 1'b1;
    return m_vld[p];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("do_a",   16'(do_a),   16'(exp_do(ptr_a)));
    chk("do_b",   16'(do_b),   16'(exp_do(ptr_b)));
    chk("vld_a",  16'(vld_a),  16'(exp_vld(ptr_a)));
    chk("vld_b",  16'(vld_b),  16'(exp_vld(ptr_b)));
    chk("do_acc", 16'(do_acc), 16'(m_acc));
    chk("wr_err", 16'(wr_err), 16'(m_err));
  endtask

  task automatic apply(input logic r, input logic w, input logic [3:0] pw, input logic [7:0] d,
                       input logic [3:0] pa, input logic [3:0] pb,
                       input logic aw, input logic ac, input logic [7:0] av);
    reset = r; we = w; ptr_w = pw; di = d; ptr_a = pa; ptr_b = pb;
    acc_we = aw; acc_clr = ac; acc_in = av;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_core[i] = 8'h00;
        m_vld[i]  = 1'b0;
      end
      m_acc = 8'h00;
      m_err = 1'b0;
    end else begin
      m_err = we && is_prot(ptr_w);
      if (we && !is_prot(ptr_w)) begin
        m_core[ptr_w] = di;
        m_vld[ptr_w]  = 1'b1;
      end
      if (acc_clr)     m_acc = 8'h00;
      else if (acc_we) m_acc = acc_in;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; ptr_w = '0; di = '0; ptr_a = '0; ptr_b = '0;
    acc_we = 1'b0; acc_clr = 1'b0; acc_in = '0;
    tick();

    // Reset state across all addresses
    for (int a = 0; a < 16; a++) begin
      apply(0, 0, 0, 0, 4'(a), 4'(a), 0, 0, 0);
      chk("rst_do_a", 16'(do_a), 16'h0);
      chk("rst_vld_a", 16'(vld_a), 16'(a == 15));
      chk("rst_vld_b", 16'(vld_b), 16'(a == 15));
      tick();
    end
    chk("rst_wr_err", 16'(wr_err), 16'h0);

    // Two writes, then a dual read
    apply(0, 1, 3, 8'hA5, 0, 0, 0, 0, 0); tick();
    apply(0, 1, 7, 8'h3C, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 3, 7, 0, 0, 0);
    chk("wr3_do_a", 16'(do_a), 16'h00A5);
    chk("wr7_do_b", 16'(do_b), 16'h003C);
    chk("wr_vld_a", 16'(vld_a), 16'h1);
    tick();

    // Protected write
    apply(0, 1, 14, 8'hFF, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 14, 14, 0, 0, 0);
    chk("prot_err", 16'(wr_err), 16'h1);
    chk("prot_do", 16'(do_a), 16'h0);
    chk("prot_vld", 16'(vld_b), 16'h0);
    tick();
    apply(0, 0, 0, 0, 14, 14, 0, 0, 0);
    chk("prot_err_gone", 16'(wr_err), 16'h0);
    tick();

    // Accumulator load then clear-over-load
    apply(0, 0, 0, 0, 15, 0, 1, 0, 8'h42); tick();
    apply(0, 0, 0, 0, 15, 0, 1, 1, 8'h99);
    chk("acc_42", 16'(do_acc), 16'h0042);
    chk("acc_alias", 16'(do_a), bypass_on() ? 16'h0000 : 16'h0042);
    tick();
    apply(0, 0, 0, 0, 15, 15, 0, 0, 0);
    chk("acc_clr", 16'(do_acc), 16'h0000);
    chk("acc_alias2", 16'(do_b), 16'h0000);
    tick();

    // Same-cycle read/write
    apply(0, 1, 5, 8'h11, 0, 0, 0, 0, 0); tick();
    apply(0, 1, 5, 8'h77, 5, 0, 0, 0, 0);
    chk("rw_same", 16'(do_a), bypass_on() ? 16'h0077 : 16'h0011);
    tick();
    apply(0, 0, 0, 0, 5, 0, 0, 0, 0);
    chk("rw_after", 16'(do_a), 16'h0077);
    tick();

    // Reset overrides a write; a protected write under reset raises no error
    apply(0, 1, 2, 8'h10, 0, 0, 0, 0, 0); tick();
    apply(1, 1, 2, 8'h20, 2, 0, 1, 0, 8'h55); tick();
    apply(0, 0, 0, 0, 2, 5, 0, 0, 0);
    chk("rst_wr_do", 16'(do_a), 16'h0);
    chk("rst_wr_vld", 16'(vld_a), 16'h0);
    chk("rst_wr_vld5", 16'(vld_b), 16'h0);
    chk("rst_wr_acc", 16'(do_acc), 16'h0);
    tick();
    apply(0, 1, 15, 8'hAA, 0, 0, 0, 0, 0); tick();
    apply(1, 1, 14, 8'hAA, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_cancel_err", 16'(wr_err), 16'h0);
    tick();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      apply(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom), 8'($urandom),
            4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
